ysyx_23060061_csr_ctrl: RTL and testbench

//  Sequencer between execute stage and the CSR register file. Accepts one decoded CSR/system op per

---
 rtl/ysyx_23060061_csr_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_ysyx_23060061_csr_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_csr_ctrl.sv
// ysyx_23060061_csr_ctrl: sequencer between execute and the CSR register file.
// Runs CSRRW/CSRRS/CSRRC read-modify-write, ECALL trap entry and MRET return,
// one request at a time, and returns the old CSR value plus any PC redirect.
module ysyx_23060061_csr_ctrl #(
   parameter  int unsigned DATA_WIDTH = 32,
   localparam int unsigned CSR_AW     = 12,
   localparam int unsigned PC_W       = 32,
   localparam int unsigned OP_W       = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_W-1:0]       req_op,
   input  logic [CSR_AW-1:0]     req_csr,
   input  logic [DATA_WIDTH-1:0] req_src,
   input  logic [PC_W-1:0]       req_pc,
   output logic                  csr_en,
   output logic [CSR_AW-1:0]     csr_id,
   output logic [DATA_WIDTH-1:0] csr_wdata,
   input  logic [DATA_WIDTH-1:0] csr_rdata,
   output logic                  csr_ecall,
   output logic [PC_W-1:0]       csr_pc,
   input  logic [PC_W-1:0]       csr_mtvec,
   input  logic [PC_W-1:0]       csr_mepc,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  redirect_valid,
   output logic [PC_W-1:0]       redirect_pc,
   output logic                  illegal
);

   localparam logic [OP_W-1:0] OP_RW    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_RS    = OP_W'(1);
   localparam logic [OP_W-1:0] OP_RC    = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ECALL = OP_W'(3);
   localparam logic [OP_W-1:0] OP_MRET  = OP_W'(4);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_TRAP  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // state and latched request
   state_t                r_state;
   logic [OP_W-1:0]       r_op;
   logic [DATA_WIDTH-1:0] r_src;
   logic [DATA_WIDTH-1:0] r_old;

   // registered outputs
   logic                  r_req_ready;
   logic                  r_csr_en;
   logic [CSR_AW-1:0]     r_csr_id;
   logic [DATA_WIDTH-1:0] r_csr_wdata;
   logic                  r_csr_ecall;
   logic [PC_W-1:0]       r_csr_pc;
   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_redirect_valid;
   logic [PC_W-1:0]       r_redirect_pc;
   logic                  r_illegal;

   // next-state values
   state_t                w_state_nxt;
   logic [OP_W-1:0]       w_op_nxt;
   logic [DATA_WIDTH-1:0] w_src_nxt;
   logic [DATA_WIDTH-1:0] w_old_nxt;
   logic                  w_req_ready_nxt;
   logic                  w_csr_en_nxt;
   logic [CSR_AW-1:0]     w_csr_id_nxt;
   logic [DATA_WIDTH-1:0] w_csr_wdata_nxt;
   logic                  w_csr_ecall_nxt;
   logic [PC_W-1:0]       w_csr_pc_nxt;
   logic                  w_resp_valid_nxt;
   logic [DATA_WIDTH-1:0] w_resp_rdata_nxt;
   logic                  w_redirect_valid_nxt;
   logic [PC_W-1:0]       w_redirect_pc_nxt;
   logic                  w_illegal_nxt;

   logic [DATA_WIDTH-1:0] w_new;
   logic                  w_skip_wr;
   logic                  w_accept;

   assign w_accept = req_valid && r_req_ready;

   // read-modify-write value; set/clear with a zero mask leaves the CSR untouched
   always_comb begin
      w_new     = csr_rdata;
      w_skip_wr = 1'b0;
      unique case (r_op)
         OP_RW:   w_new = r_src;
         OP_RS:   w_new = csr_rdata | r_src;
         OP_RC:   w_new = csr_rdata & ~r_src;
         default: w_new = csr_rdata;
      endcase
      if (((r_op == OP_RS) || (r_op == OP_RC)) && (r_src == '0)) begin
         w_skip_wr = 1'b1;
      end
   end

   // next state and next registered outputs; defaults hold everything (RESP back-pressure freeze)
   always_comb begin
      w_state_nxt          = r_state;
      w_op_nxt             = r_op;
      w_src_nxt            = r_src;
      w_old_nxt            = r_old;
      w_req_ready_nxt      = 1'b0;
      w_csr_en_nxt         = 1'b0;
      w_csr_id_nxt         = r_csr_id;
      w_csr_wdata_nxt      = r_csr_wdata;
      w_csr_ecall_nxt      = 1'b0;
      w_csr_pc_nxt         = r_csr_pc;
      w_resp_valid_nxt     = r_resp_valid;
      w_resp_rdata_nxt     = r_resp_rdata;
      w_redirect_valid_nxt = r_redirect_valid;
      w_redirect_pc_nxt    = r_redirect_pc;
      w_illegal_nxt        = r_illegal;

      unique case (r_state)
         ST_IDLE: begin
            w_req_ready_nxt = 1'b1;
            if (w_accept) begin
               w_req_ready_nxt = 1'b0;
               w_op_nxt        = req_op;
               w_src_nxt       = req_src;
               w_csr_id_nxt    = req_csr;
               w_csr_pc_nxt    = req_pc;
               unique case (req_op)
                  OP_RW, OP_RS, OP_RC: begin
                     w_state_nxt = ST_READ;
                  end
                  OP_ECALL: begin
                     w_state_nxt     = ST_TRAP;
                     w_csr_ecall_nxt = 1'b1;
                  end
                  OP_MRET: begin
                     w_state_nxt          = ST_RESP;
                     w_resp_valid_nxt     = 1'b1;
                     w_resp_rdata_nxt     = '0;
                     w_redirect_valid_nxt = 1'b1;
                     w_redirect_pc_nxt    = csr_mepc;
                     w_illegal_nxt        = 1'b0;
                  end
                  default: begin
                     w_state_nxt          = ST_RESP;
                     w_resp_valid_nxt     = 1'b1;
                     w_resp_rdata_nxt     = '0;
                     w_redirect_valid_nxt = 1'b0;
                     w_illegal_nxt        = 1'b1;
                  end
               endcase
            end
         end
         ST_READ: begin
            w_state_nxt     = ST_WRITE;
            w_old_nxt       = csr_rdata;
            w_csr_wdata_nxt = w_new;
            w_csr_en_nxt    = !w_skip_wr;
         end
         ST_WRITE: begin
            w_state_nxt          = ST_RESP;
            w_resp_valid_nxt     = 1'b1;
            w_resp_rdata_nxt     = r_old;
            w_redirect_valid_nxt = 1'b0;
            w_illegal_nxt        = 1'b0;
         end
         ST_TRAP: begin
            w_state_nxt          = ST_RESP;
            w_resp_valid_nxt     = 1'b1;
            w_resp_rdata_nxt     = '0;
            w_redirect_valid_nxt = 1'b1;
            w_redirect_pc_nxt    = csr_mtvec;
            w_illegal_nxt        = 1'b0;
         end
         ST_RESP: begin
            if (resp_ready) begin
               w_state_nxt          = ST_IDLE;
               w_req_ready_nxt      = 1'b1;
               w_resp_valid_nxt     = 1'b0;
               w_resp_rdata_nxt     = '0;
               w_redirect_valid_nxt = 1'b0;
               w_illegal_nxt        = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // state and output registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= ST_IDLE;
         r_op             <= '0;
         r_src            <= '0;
         r_old            <= '0;
         r_req_ready      <= 1'b0;
         r_csr_en         <= 1'b0;
         r_csr_id         <= '0;
         r_csr_wdata      <= '0;
         r_csr_ecall      <= 1'b0;
         r_csr_pc         <= '0;
         r_resp_valid     <= 1'b0;
         r_resp_rdata     <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_illegal        <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_op             <= w_op_nxt;
         r_src            <= w_src_nxt;
         r_old            <= w_old_nxt;
         r_req_ready      <= w_req_ready_nxt;
         r_csr_en         <= w_csr_en_nxt;
         r_csr_id         <= w_csr_id_nxt;
         r_csr_wdata      <= w_csr_wdata_nxt;
         r_csr_ecall      <= w_csr_ecall_nxt;
         r_csr_pc         <= w_csr_pc_nxt;
         r_resp_valid     <= w_resp_valid_nxt;
         r_resp_rdata     <= w_resp_rdata_nxt;
         r_redirect_valid <= w_redirect_valid_nxt;
         r_redirect_pc    <= w_redirect_pc_nxt;
         r_illegal        <= w_illegal_nxt;
      end
   end

   assign req_ready      = r_req_ready;
   assign csr_en         = r_csr_en;
   assign csr_id         = r_csr_id;
   assign csr_wdata      = r_csr_wdata;
   assign csr_ecall      = r_csr_ecall;
   assign csr_pc         = r_csr_pc;
   assign resp_valid     = r_resp_valid;
   assign resp_rdata     = r_resp_rdata;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign illegal        = r_illegal;

endmodule

// File: tb/tb_ysyx_23060061_csr_ctrl.sv
// Testbench for ysyx_23060061_csr_ctrl: directed vector table plus
// hand-written back-pressure and reset-during-write sequences.
module tb_ysyx_23060061_csr_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_csr;
   logic [31:0] req_src;
   logic [31:0] req_pc;
   logic        csr_en;
   logic [11:0] csr_id;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_ecall;
   logic [31:0] csr_pc;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        illegal;

   int n_cmp;
   int n_err;

   ysyx_23060061_csr_ctrl #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_csr        (req_csr),
      .req_src        (req_src),
      .req_pc         (req_pc),
      .csr_en         (csr_en),
      .csr_id         (csr_id),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .csr_ecall      (csr_ecall),
      .csr_pc         (csr_pc),
      .csr_mtvec      (csr_mtvec),
      .csr_mepc       (csr_mepc),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_rdata     (resp_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .illegal        (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fixed CSR file contents seen by the controller
   localparam logic [31:0] MSTATUS = 32'h0000_1800;
   localparam logic [31:0] MTVEC   = 32'h8000_0100;
   localparam logic [31:0] MEPC    = 32'h8000_0044;

   assign csr_mtvec = MTVEC;
   assign csr_mepc  = MEPC;

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_id)
         12'h300: csr_rdata = MSTATUS;
         12'h305: csr_rdata = MTVEC;
         12'h341: csr_rdata = MEPC;
         default: csr_rdata = 32'h0;
      endcase
   end

   typedef struct {
      logic [2:0]  op;
      logic [11:0] csr;
      logic [31:0] src;
      logic [31:0] pc;
      int          lat;
      int          n_en;
      logic [31:0] wdata;
      int          n_ecall;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] redir_pc;
      logic        ill;
      string       name;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!req_ready && n < 10) begin
         step();
         n++;
      end
      chk({name, "_req_ready"}, 32'(req_ready), 32'h1);
   endtask

   task automatic run_vec(input vec_t v);
      int          n_en, n_ec, resp_c, en_c, ec_c;
      logic [31:0] wd, ecpc, rd, rpc;
      logic [11:0] id_en;
      logic        rv, il;
      n_en = 0; n_ec = 0; resp_c = -1; en_c = -1; ec_c = -1;
      wd = '0; ecpc = '0; rd = '0; rpc = '0; id_en = '0; rv = 1'b0; il = 1'b0;
      wait_ready(v.name);
      req_valid = 1'b1;
      req_op    = v.op;
      req_csr   = v.csr;
      req_src   = v.src;
      req_pc    = v.pc;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (csr_en) begin
            n_en++; wd = csr_wdata; id_en = csr_id; en_c = c;
         end
         if (csr_ecall) begin
            n_ec++; ecpc = csr_pc; ec_c = c;
         end
         if (resp_valid) begin
            resp_c = c; rd = resp_rdata; rv = redirect_valid; rpc = redirect_pc; il = illegal;
            break;
         end
         step();
      end
      step();
      chk({v.name, "_latency"}, 32'(resp_c), 32'(v.lat));
      chk({v.name, "_en_count"}, 32'(n_en), 32'(v.n_en));
      chk({v.name, "_ecall_count"}, 32'(n_ec), 32'(v.n_ecall));
      if (v.n_en > 0) begin
         chk({v.name, "_en_cycle"}, 32'(en_c), 32'd2);
         chk({v.name, "_wdata"}, wd, v.wdata);
         chk({v.name, "_id"}, 32'(id_en), 32'(v.csr));
      end
      if (v.n_ecall > 0) begin
         chk({v.name, "_ecall_cycle"}, 32'(ec_c), 32'd1);
         chk({v.name, "_ecall_pc"}, ecpc, v.pc);
      end
      chk({v.name, "_rdata"}, rd, v.rdata);
      chk({v.name, "_redir_valid"}, 32'(rv), 32'(v.redir));
      if (v.redir) chk({v.name, "_redir_pc"}, rpc, v.redir_pc);
      chk({v.name, "_illegal"}, 32'(il), 32'(v.ill));
      chk({v.name, "_resp_cleared"}, 32'(resp_valid), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_op     = 3'd0;
      req_csr    = 12'h0;
      req_src    = 32'h0;
      req_pc     = 32'h0;
      resp_ready = 1'b1;

      //           op    csr      src           pc            lat en wdata         ec rdata         rd  rpc           il
      vecs[0] = '{3'd0, 12'h305, 32'h8000_0200, 32'h8000_0000, 3, 1, 32'h8000_0200, 0, 32'h8000_0100, 1'b0, 32'h0, 1'b0, "csrrw_mtvec"};
      vecs[1] = '{3'd1, 12'h300, 32'h0000_0008, 32'h8000_0004, 3, 1, 32'h0000_1808, 0, 32'h0000_1800, 1'b0, 32'h0, 1'b0, "csrrs_mstatus"};
      vecs[2] = '{3'd2, 12'h300, 32'h0000_0800, 32'h8000_0008, 3, 1, 32'h0000_1000, 0, 32'h0000_1800, 1'b0, 32'h0, 1'b0, "csrrc_mstatus"};
      vecs[3] = '{3'd1, 12'h300, 32'h0000_0000, 32'h8000_000c, 3, 0, 32'h0,         0, 32'h0000_1800, 1'b0, 32'h0, 1'b0, "csrrs_zero"};
      vecs[4] = '{3'd2, 12'h341, 32'h0000_0000, 32'h8000_0010, 3, 0, 32'h0,         0, 32'h8000_0044, 1'b0, 32'h0, 1'b0, "csrrc_zero"};
      vecs[5] = '{3'd0, 12'h341, 32'h0000_0000, 32'h8000_0014, 3, 1, 32'h0000_0000, 0, 32'h8000_0044, 1'b0, 32'h0, 1'b0, "csrrw_zero"};
      vecs[6] = '{3'd3, 12'h000, 32'h0000_0000, 32'h8000_0040, 2, 0, 32'h0,         1, 32'h0,         1'b1, 32'h8000_0100, 1'b0, "ecall"};
      vecs[7] = '{3'd4, 12'h000, 32'h0000_0000, 32'h8000_0048, 1, 0, 32'h0,         0, 32'h0,         1'b1, 32'h8000_0044, 1'b0, "mret"};
      vecs[8] = '{3'd7, 12'h300, 32'h0000_00ff, 32'h8000_004c, 1, 0, 32'h0,         0, 32'h0,         1'b0, 32'h0, 1'b1, "illegal_7"};
      vecs[9] = '{3'd5, 12'h305, 32'h0000_0001, 32'h8000_0050, 1, 0, 32'h0,         0, 32'h0,         1'b0, 32'h0, 1'b1, "illegal_5"};

      // reset state
      step();
      step();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_csr_en", 32'(csr_en), 32'h0);
      chk("rst_csr_ecall", 32'(csr_ecall), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post_rst_req_ready", 32'(req_ready), 32'h1);

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i]);
      end

      // MRET held under back-pressure, then a request offered during the handshake cycle
      wait_ready("bp");
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_op     = 3'd4;
      req_pc     = 32'h8000_0060;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_resp_valid", 32'(resp_valid), 32'h1);
         chk("bp_redir_pc", redirect_pc, 32'h8000_0044);
         chk("bp_redir_valid", 32'(redirect_valid), 32'h1);
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         step();
      end
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_op     = 3'd6;
      step();
      chk("hs_no_accept_resp", 32'(resp_valid), 32'h0);
      chk("hs_ready_again", 32'(req_ready), 32'h1);
      step();
      req_valid = 1'b0;
      chk("after_hs_illegal_resp", 32'(resp_valid), 32'h1);
      chk("after_hs_illegal", 32'(illegal), 32'h1);
      step();

      // reset dropped while a CSRRW is in its write cycle
      wait_ready("rstw");
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_csr   = 12'h305;
      req_src   = 32'h1234_5678;
      step();
      req_valid = 1'b0;
      step();
      chk("rstw_en_before", 32'(csr_en), 32'h1);
      rst = 1'b0;
      #1;
      chk("rstw_csr_en", 32'(csr_en), 32'h0);
      chk("rstw_csr_id", 32'(csr_id), 32'h0);
      chk("rstw_csr_wdata", csr_wdata, 32'h0);
      chk("rstw_req_ready", 32'(req_ready), 32'h0);
      chk("rstw_resp_valid", 32'(resp_valid), 32'h0);
      chk("rstw_redir_pc", redirect_pc, 32'h0);
      step();
      chk("rstw_resp_valid_held", 32'(resp_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("rstw_idle_ready", 32'(req_ready), 32'h1);
      chk("rstw_idle_resp", 32'(resp_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
